div_sample_ctrl: RTL

DIV_SAMPLE_CTRL -- requirements
Module: div_sample_ctrl

---
 rtl/div_sample_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/div_sample_ctrl.sv
// Slow-tick sampler: divides clk_in by a latched ratio N and captures K serial
// bits of d_in into a shift register, one bit per slow tick.
module div_sample_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_SAMP = 16
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    div_ratio,
    input  logic [4:0]          num_samples,
    input  logic                d_in,
    output logic                busy,
    output logic                tick,
    output logic [MAX_SAMP-1:0] sample_q,
    output logic                done,
    output logic                err
);

    localparam int unsigned K_W   = 5;
    // num_samples cannot exceed 31, so clamp the capacity limit to that range
    localparam int unsigned MAX_K = (MAX_SAMP > 31) ? 31 : MAX_SAMP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] tick_cnt;
    logic [K_W-1:0]   k_lat;
    logic [K_W-1:0]   samp_cnt;

    logic             cfg_valid_c;
    logic [CNT_W-1:0] n_last_c;
    logic             wrap_c;
    logic [CNT_W-1:0] tick_cnt_nxt_c;
    logic             last_samp_c;

    always_comb begin
        cfg_valid_c    = (div_ratio >= CNT_W'(2)) && (num_samples != K_W'(0))
                         && (num_samples <= K_W'(MAX_K));
        n_last_c       = n_lat - CNT_W'(1);
        wrap_c         = (tick_cnt == n_last_c);
        tick_cnt_nxt_c = wrap_c ? '0 : tick_cnt + CNT_W'(1);
        last_samp_c    = ((samp_cnt + K_W'(1)) == k_lat);
    end

    // Single-process FSM; tick/busy/done/err are registered for the cycle they describe
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            n_lat    <= '0;
            k_lat    <= '0;
            tick_cnt <= '0;
            samp_cnt <= '0;
            sample_q <= '0;
            busy     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_valid_c) begin
                            n_lat    <= div_ratio;
                            k_lat    <= num_samples;
                            tick_cnt <= '0;
                            samp_cnt <= '0;
                            sample_q <= '0;
                            busy     <= 1'b1;
                            tick     <= 1'b0;
                            state    <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // abort beats a coincident tick: no capture on this edge
                        busy  <= 1'b0;
                        tick  <= 1'b0;
                        state <= IDLE;
                    end else if (wrap_c) begin
                        sample_q <= {sample_q[MAX_SAMP-2:0], d_in};
                        samp_cnt <= samp_cnt + K_W'(1);
                        tick_cnt <= tick_cnt_nxt_c;
                        tick     <= 1'b0;
                        if (last_samp_c) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        tick_cnt <= tick_cnt_nxt_c;
                        tick     <= (tick_cnt_nxt_c == n_last_c);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    tick  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
